// File: rtl/abr_params_pkg.sv
// Shared memory-interface parameters used by the signature encode/decode paths.
package abr_params_pkg;

  localparam int ABR_MEM_ADDR_WIDTH = 15;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_READ  = 2'b01,
    RW_WRITE = 2'b10
  } mem_rw_mode_e;

endpackage

// File: rtl/sigencode_z_defines_pkg.sv
// Constants, state encoding and memory request format for the z signature encoder.
package sigencode_z_defines_pkg;
  import abr_params_pkg::*;

  localparam int API_ADDR_WIDTH  = ABR_MEM_ADDR_WIDTH;

  localparam int MLDSA_L         = 7;
  localparam int MLDSA_N         = 256;
  localparam int COEFF_W         = 24;
  localparam int ENC_W           = 20;
  localparam int COEFFS_PER_WORD = 4;
  localparam int NUM_WORDS       = MLDSA_L * MLDSA_N / COEFFS_PER_WORD;

  localparam logic [COEFF_W-1:0] MLDSA_Q      = 24'd8380417;
  localparam logic [COEFF_W-1:0] MLDSA_GAMMA1 = 24'h080000;

  localparam logic [8:0] LAST_WORD = 9'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sigenc_state_e;

  typedef struct packed {
    mem_rw_mode_e              rd_wr_en;
    logic [API_ADDR_WIDTH-1:0] addr;
  } sig_mem_if_t;

endpackage

// File: rtl/sigencode_z_unit.sv
// Single-coefficient z map: c -> (GAMMA1 - c) mod q, truncated to 20 bits,
// with a flag when the input or the centred result falls outside its range.
module sigencode_z_unit
  import sigencode_z_defines_pkg::*;
(
  input  logic [COEFF_W-1:0] coeff,
  output logic [ENC_W-1:0]   enc,
  output logic               err
);

  logic signed [25:0] t_raw;
  logic signed [25:0] t_fin;

  // Subtract from gamma1 and fold negative results back by adding q.
  always_comb begin
    t_raw = $signed({2'b00, MLDSA_GAMMA1}) - $signed({2'b00, coeff});
    t_fin = t_raw;
    if (t_raw < 0) begin
      t_fin = t_raw + $signed({2'b00, MLDSA_Q});
    end
    enc = t_fin[ENC_W-1:0];
    // Upper bits also catch a still-negative result when coeff >= q.
    err = (coeff >= MLDSA_Q) || (t_fin[25:ENC_W] != 6'd0);
  end

endmodule

// File: rtl/sigencode_z_top.sv
// z signature encoder: reads 448 words of packed z coefficients, maps each
// coefficient, and streams 80-bit packed words through a 2-entry FIFO.
//
//  state    | meaning
//  ST_IDLE  | waiting for start
//  ST_RUN   | issuing memory reads, credit-limited to FIFO space
//  ST_DRAIN | all reads issued, emptying the FIFO downstream
//  ST_DONE  | one-cycle done pulse
module sigencode_z_top
  import abr_params_pkg::*;
  import sigencode_z_defines_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      zeroize,
  input  logic                      start,
  input  logic [API_ADDR_WIDTH-1:0] src_base_addr,
  output sig_mem_if_t               mem_rd_req,
  input  logic [95:0]               mem_rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [79:0]               out_data,
  output logic                      busy,
  output logic                      done,
  output logic                      range_err
);

  sigenc_state_e             state, state_nxt;
  logic [API_ADDR_WIDTH-1:0] base_addr;
  logic [8:0]                rd_cnt;
  logic [8:0]                out_cnt;
  logic                      inflight;
  logic [79:0]               fifo_mem [2];
  logic                      wr_ptr, rd_ptr;
  logic [1:0]                fifo_cnt;
  logic [1:0]                credit;
  logic                      issue, push, pop, start_ok;
  logic [79:0]               enc_word;
  logic [3:0]                enc_err;

  for (genvar i = 0; i < COEFFS_PER_WORD; i++) begin : g_unit
    sigencode_z_unit u_unit (
      .coeff (mem_rd_data[COEFF_W*i +: COEFF_W]),
      .enc   (enc_word[ENC_W*i +: ENC_W]),
      .err   (enc_err[i])
    );
  end

  assign credit    = fifo_cnt + {1'b0, inflight};
  assign issue     = (state == ST_RUN) && (credit < 2'd2);
  assign push      = inflight;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign start_ok  = (state == ST_IDLE) && start;

  // Read request is only driven while a read is actually issued.
  always_comb begin
    mem_rd_req.rd_wr_en = RW_IDLE;
    mem_rd_req.addr     = '0;
    if (issue) begin
      mem_rd_req.rd_wr_en = RW_READ;
      mem_rd_req.addr     = base_addr + {{(API_ADDR_WIDTH-9){1'b0}}, rd_cnt};
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (issue && (rd_cnt == LAST_WORD)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && (out_cnt == LAST_WORD)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, counters, FIFO and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      state       <= ST_IDLE;
      base_addr   <= '0;
      rd_cnt      <= '0;
      out_cnt     <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= '0;
      range_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (start_ok) begin
        base_addr <= src_base_addr;
        rd_cnt    <= '0;
        out_cnt   <= '0;
        range_err <= 1'b0;
      end
      if (issue) rd_cnt <= rd_cnt + 9'd1;
      if (pop) begin
        out_cnt <= out_cnt + 9'd1;
        rd_ptr  <= ~rd_ptr;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= enc_word;
        wr_ptr           <= ~wr_ptr;
        if (enc_err != 4'd0) range_err <= 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
